// File: rtl/led_pio_pkg.sv
// Shared register map and STATUS bit positions for the multi-bit LED PIO.
package led_pio_pkg;

    localparam logic [2:0] ADDR_DATA      = 3'd0;
    localparam logic [2:0] ADDR_SET       = 3'd1;
    localparam logic [2:0] ADDR_CLEAR     = 3'd2;
    localparam logic [2:0] ADDR_BLINK_EN  = 3'd3;
    localparam logic [2:0] ADDR_BLINK_DIV = 3'd4;
    localparam logic [2:0] ADDR_STATUS    = 3'd5;
    localparam logic [2:0] ADDR_DUTY      = 3'd6;

    localparam int unsigned STATUS_PHASE_BIT   = 0;
    localparam int unsigned STATUS_RUNNING_BIT = 1;

endpackage

// File: rtl/led_pio_blink_timer.sv
// Blink half-period timer: cnt runs 0..div, phase toggles on wrap; div == 0 holds phase high.
module led_pio_blink_timer #(
    parameter int unsigned DIV_W = 24
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [DIV_W-1:0] div,
    input  logic             div_wr,
    output logic             phase,
    output logic             running
);

    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic             phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q + 1'b1;
        phase_d = phase_q;
        // A divider write restarts the period so the first toggle lands div+1 cycles later.
        if (div_wr || (div == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b1;
        end else if (cnt_q == div) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b1;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase   = phase_q;
    assign running = (div != '0);

endmodule

// File: rtl/led_pio_multi.sv
// Avalon-MM LED/GPIO PIO with set/clear, per-bit blink and registered output.
// Optional PWM dimming (DUTY register) is enabled by defining LED_PIO_PWM_EN.
module led_pio_multi
    import led_pio_pkg::*;
#(
    parameter int unsigned     WIDTH       = 4,
    parameter int unsigned     DIV_W       = 24,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic             wr;
    logic             div_wr;
    logic             phase;
    logic             running;
    logic [WIDTH-1:0] wdata;
    logic [WIDTH-1:0] blink_result;
    logic             unused_wdata;

    logic [WIDTH-1:0] data_q, data_d;
    logic [WIDTH-1:0] blink_en_q, blink_en_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [WIDTH-1:0] out_q, out_d;

    assign wr           = chipselect & ~write_n;
    assign div_wr       = wr && (address == ADDR_BLINK_DIV);
    assign wdata        = writedata[WIDTH-1:0];
    assign unused_wdata = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        div_d      = div_q;
        if (wr) begin
            case (address)
                ADDR_DATA:      data_d     = wdata;
                ADDR_SET:       data_d     = data_q | wdata;
                ADDR_CLEAR:     data_d     = data_q & ~wdata;
                ADDR_BLINK_EN:  blink_en_d = wdata;
                ADDR_BLINK_DIV: div_d      = writedata[DIV_W-1:0];
                default:        ;
            endcase
        end
    end

    led_pio_blink_timer #(
        .DIV_W (DIV_W)
    ) u_blink_timer (
        .clk     (clk),
        .reset   (reset),
        .div     (div_q),
        .div_wr  (div_wr),
        .phase   (phase),
        .running (running)
    );

    assign blink_result = data_q & ~(blink_en_q & {WIDTH{~phase}});

`ifdef LED_PIO_PWM_EN
    logic [7:0] duty_q, duty_d;
    logic [7:0] pwm_cnt_q;

    always_comb begin
        duty_d = duty_q;
        if (wr && (address == ADDR_DUTY)) begin
            duty_d = writedata[7:0];
        end
        out_d = blink_result & {WIDTH{pwm_cnt_q < duty_q}};
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            duty_q    <= 8'hFF;
            pwm_cnt_q <= 8'h00;
        end else begin
            duty_q    <= duty_d;
            pwm_cnt_q <= pwm_cnt_q + 8'd1;
        end
    end
`else
    assign out_d = blink_result;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            div_q      <= '0;
            out_q      <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            div_q      <= div_d;
            out_q      <= out_d;
        end
    end

    assign out_port = out_q;

    // Zero-wait read path: pure function of address and current register state.
    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:      readdata[WIDTH-1:0] = data_q;
            ADDR_BLINK_EN:  readdata[WIDTH-1:0] = blink_en_q;
            ADDR_BLINK_DIV: readdata[DIV_W-1:0] = div_q;
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT]   = phase;
                readdata[STATUS_RUNNING_BIT] = running;
            end
`ifdef LED_PIO_PWM_EN
            ADDR_DUTY:      readdata[7:0] = duty_q;
`endif
            default:        ;
        endcase
    end

endmodule
